// File: rtl/vtpg_pkg.sv
// Shared definitions for the video timing pattern generator control path:
// controller state encoding and the cfg_field index constants used by both
// the mode controller and the generator's register block.
package vtpg_pkg;

  // Controller states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    WAIT_VS = 3'd2,
    HOLD    = 3'd3,
    LOAD    = 3'd4
  } ctrlState_e;

  // cfg_field indices; 9..15 select nothing
  localparam logic [3:0] FLD_H_END      = 4'd0;
  localparam logic [3:0] FLD_HS_START   = 4'd1;
  localparam logic [3:0] FLD_HS_END     = 4'd2;
  localparam logic [3:0] FLD_HACT_START = 4'd3;
  localparam logic [3:0] FLD_HACT_END   = 4'd4;
  localparam logic [3:0] FLD_VS_START   = 4'd5;
  localparam logic [3:0] FLD_VS_END     = 4'd6;
  localparam logic [3:0] FLD_VACT_START = 4'd7;
  localparam logic [3:0] FLD_VACT_END   = 4'd8;

  // Horizontal fields occupy indices 0..4, vertical fields 5..8
  localparam int NUM_H_FIELDS = 5;
  localparam int NUM_V_FIELDS = 4;

  // True when the field index selects a horizontal timing
  function automatic logic fieldIsH(input logic [3:0] fld);
    return fld <= FLD_HACT_END;
  endfunction

  // True when the field index selects a vertical timing
  function automatic logic fieldIsV(input logic [3:0] fld);
    return (fld >= FLD_VS_START) && (fld <= FLD_VACT_END);
  endfunction

endpackage

// File: rtl/vtpg_mode_ctrl_if.sv
// Register/CPU side bus of the mode controller: mode-table write port plus
// the mode-switch / stop request handshake.
interface vtpg_mode_ctrl_if #(
  parameter int MODE_BITS = 2
);
  logic                 cfg_wr;
  logic [MODE_BITS-1:0] cfg_mode;
  logic [3:0]           cfg_field;
  logic [15:0]          cfg_data;
  logic                 req_valid;
  logic                 req_ready;
  logic [MODE_BITS-1:0] req_mode;
  logic                 req_stop;

  // Register/CPU side
  modport master (
    output cfg_wr, cfg_mode, cfg_field, cfg_data,
    output req_valid, req_mode, req_stop,
    input  req_ready
  );

  // Mode controller side
  modport slave (
    input  cfg_wr, cfg_mode, cfg_field, cfg_data,
    input  req_valid, req_mode, req_stop,
    output req_ready
  );
endinterface

// File: rtl/vtpg_mode_table.sv
// Mode preset table: NUM_MODES entries of nine timing fields each, one write
// port and an unregistered read port. Reads are combinational so a write on
// the same edge as a LOAD of that entry is seen only by later loads.
module vtpg_mode_table
  import vtpg_pkg::*;
#(
  parameter int H_BITS    = 12,
  parameter int V_BITS    = 12,
  parameter int MODE_BITS = 2
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     wrEn,
  input  logic [MODE_BITS-1:0]                     wrMode,
  input  logic [3:0]                               wrField,
  input  logic [15:0]                              wrData,
  input  logic [MODE_BITS-1:0]                     rdMode,
  output logic [NUM_H_FIELDS-1:0][H_BITS-1:0]      rdH,
  output logic [NUM_V_FIELDS-1:0][V_BITS-1:0]      rdV
);

  localparam int NUM_MODES = 2 ** MODE_BITS;

  logic [NUM_H_FIELDS-1:0][H_BITS-1:0] hAll [NUM_MODES];
  logic [NUM_V_FIELDS-1:0][V_BITS-1:0] vAll [NUM_MODES];

  logic [2:0] hIdx;
  logic [1:0] vIdx;

  assign hIdx = wrField[2:0];
  assign vIdx = 2'(wrField - FLD_VS_START);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MODES; gi++) begin : gEntry
      logic [NUM_H_FIELDS-1:0][H_BITS-1:0] hEnt;
      logic [NUM_V_FIELDS-1:0][V_BITS-1:0] vEnt;

      // Field write into this entry; out-of-range field indices are dropped
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hEnt <= '0;
          vEnt <= '0;
        end else if (wrEn && (wrMode == MODE_BITS'(gi))) begin
          if (fieldIsH(wrField)) begin
            hEnt[hIdx] <= wrData[H_BITS-1:0];
          end else if (fieldIsV(wrField)) begin
            vEnt[vIdx] <= wrData[V_BITS-1:0];
          end
        end
      end

      assign hAll[gi] = hEnt;
      assign vAll[gi] = vEnt;
    end
  endgenerate

  assign rdH = hAll[rdMode];
  assign rdV = vAll[rdMode];

endmodule

// File: rtl/vtpg_mode_ctrl.sv
// Mode controller for the video timing pattern generator. Accepts mode-switch
// and stop requests, waits for a vsync boundary when the generator is running,
// holds the generator in reset, loads the new timing set and releases it.
// Optional build macro VTPG_CTRL_CHECK_EN: validate the entry at LOAD and
// refuse (err_cfg, back to IDLE) an inconsistent timing set.
module vtpg_mode_ctrl
  import vtpg_pkg::*;
#(
  parameter int H_BITS    = 12,
  parameter int V_BITS    = 12,
  parameter int MODE_BITS = 2,
  parameter int HOLD_CYC  = 2,
  parameter int TIMEOUT   = 1048576
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vtpg_mode_ctrl_if.slave      bus,
  input  logic                 vs,
  output logic                 gen_rst_n,
  output logic [H_BITS-1:0]    tH_END,
  output logic [H_BITS-1:0]    tHS_START,
  output logic [H_BITS-1:0]    tHS_END,
  output logic [H_BITS-1:0]    tHACT_START,
  output logic [H_BITS-1:0]    tHACT_END,
  output logic [V_BITS-1:0]    tVS_START,
  output logic [V_BITS-1:0]    tVS_END,
  output logic [V_BITS-1:0]    tVACT_START,
  output logic [V_BITS-1:0]    tVACT_END,
  output logic [MODE_BITS-1:0] active_mode,
  output logic                 busy,
  output logic [15:0]          frame_cnt,
  output logic                 err_timeout,
  output logic                 err_cfg
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int HC_W = $clog2(HOLD_CYC + 1);

  ctrlState_e                          state;
  logic                                vsQ;
  logic                                vsRise;
  logic                                accept;
  logic [MODE_BITS-1:0]                pendMode;
  logic                                pendStop;
  logic [HC_W-1:0]                     holdCnt;
  logic [TO_W-1:0]                     toCnt;
  logic                                genRstN;
  logic [NUM_H_FIELDS-1:0][H_BITS-1:0] hOut;
  logic [NUM_V_FIELDS-1:0][V_BITS-1:0] vOut;
  logic [MODE_BITS-1:0]                activeMode;
  logic [15:0]                         frameCnt;
  logic                                errTimeout;
  logic [NUM_H_FIELDS-1:0][H_BITS-1:0] rdH;
  logic [NUM_V_FIELDS-1:0][V_BITS-1:0] rdV;

  vtpg_mode_table #(
    .H_BITS    (H_BITS),
    .V_BITS    (V_BITS),
    .MODE_BITS (MODE_BITS)
  ) uTable (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrEn    (bus.cfg_wr),
    .wrMode  (bus.cfg_mode),
    .wrField (bus.cfg_field),
    .wrData  (bus.cfg_data),
    .rdMode  (pendMode),
    .rdH     (rdH),
    .rdV     (rdV)
  );

  assign vsRise        = vs & ~vsQ;
  assign bus.req_ready = (state == IDLE) || (state == RUN);
  assign accept        = bus.req_valid & bus.req_ready;
  assign busy          = (state == WAIT_VS) || (state == HOLD) || (state == LOAD);

`ifdef VTPG_CTRL_CHECK_EN
  logic errCfgReg;
  logic cfgOk;

  // Entry consistency: sync pulses and active regions ordered and inside the line
  assign cfgOk = (rdH[1] <  rdH[2]) && (rdH[2] <= rdH[0]) &&
                 (rdH[3] <  rdH[4]) && (rdH[4] <= rdH[0]) &&
                 (rdV[0] <  rdV[1]) &&
                 (rdV[2] <  rdV[3]);
  assign err_cfg = errCfgReg;
`else
  assign err_cfg = 1'b0;
`endif

  // Control FSM with all generator-facing outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vsQ        <= 1'b0;
      pendMode   <= '0;
      pendStop   <= 1'b0;
      holdCnt    <= '0;
      toCnt      <= '0;
      genRstN    <= 1'b0;
      hOut       <= '0;
      vOut       <= '0;
      activeMode <= '0;
      frameCnt   <= '0;
      errTimeout <= 1'b0;
`ifdef VTPG_CTRL_CHECK_EN
      errCfgReg  <= 1'b0;
`endif
    end else begin
      vsQ <= vs;

      // A new request latches its target and clears the sticky errors
      if (accept) begin
        pendMode   <= bus.req_mode;
        pendStop   <= bus.req_stop;
        errTimeout <= 1'b0;
`ifdef VTPG_CTRL_CHECK_EN
        errCfgReg  <= 1'b0;
`endif
      end

      unique case (state)
        IDLE: begin
          // Generator already in reset: no vsync wait; a stop is a no-op
          if (accept && !bus.req_stop) begin
            holdCnt <= '0;
            state   <= HOLD;
          end
        end

        RUN: begin
          if (vsRise) begin
            frameCnt <= frameCnt + 16'd1;
          end
          if (accept) begin
            toCnt <= '0;
            state <= WAIT_VS;
          end
        end

        WAIT_VS: begin
          if (vsRise) begin
            genRstN <= 1'b0;
            holdCnt <= '0;
            state   <= HOLD;
          end else if (toCnt == TO_W'(TIMEOUT - 1)) begin
            // No vsync seen: force the switch and flag it
            errTimeout <= 1'b1;
            genRstN    <= 1'b0;
            holdCnt    <= '0;
            state      <= HOLD;
          end else begin
            toCnt <= toCnt + TO_W'(1);
          end
        end

        HOLD: begin
          if (holdCnt == HC_W'(HOLD_CYC)) begin
            state <= pendStop ? IDLE : LOAD;
          end else begin
            holdCnt <= holdCnt + HC_W'(1);
          end
        end

        LOAD: begin
`ifdef VTPG_CTRL_CHECK_EN
          if (!cfgOk) begin
            // Refuse the entry: keep previous timings, generator stays in reset
            errCfgReg <= 1'b1;
            state     <= IDLE;
          end else begin
`else
          begin
`endif
            hOut       <= rdH;
            vOut       <= rdV;
            activeMode <= pendMode;
            frameCnt   <= '0;
            genRstN    <= 1'b1;
            state      <= RUN;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign gen_rst_n   = genRstN;
  assign tH_END      = hOut[0];
  assign tHS_START   = hOut[1];
  assign tHS_END     = hOut[2];
  assign tHACT_START = hOut[3];
  assign tHACT_END   = hOut[4];
  assign tVS_START   = vOut[0];
  assign tVS_END     = vOut[1];
  assign tVACT_START = vOut[2];
  assign tVACT_END   = vOut[3];
  assign active_mode = activeMode;
  assign frame_cnt   = frameCnt;
  assign err_timeout = errTimeout;

endmodule

// File: tb/tb_vtpg_mode_ctrl.sv
// Directed bench for vtpg_mode_ctrl (HOLD_CYC=2, TIMEOUT=16).
module tb_vtpg_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vs;
  logic        gen_rst_n;
  logic [11:0] tH_END, tHS_START, tHS_END, tHACT_START, tHACT_END;
  logic [11:0] tVS_START, tVS_END, tVACT_START, tVACT_END;
  logic [1:0]  active_mode;
  logic        busy;
  logic [15:0] frame_cnt;
  logic        err_timeout;
  logic        err_cfg;

  int passed = 0;
  int total  = 0;

  vtpg_mode_ctrl_if #(.MODE_BITS(2)) bus ();

  vtpg_mode_ctrl #(
    .H_BITS(12), .V_BITS(12), .MODE_BITS(2), .HOLD_CYC(2), .TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .vs(vs), .gen_rst_n(gen_rst_n),
    .tH_END(tH_END), .tHS_START(tHS_START), .tHS_END(tHS_END),
    .tHACT_START(tHACT_START), .tHACT_END(tHACT_END),
    .tVS_START(tVS_START), .tVS_END(tVS_END),
    .tVACT_START(tVACT_START), .tVACT_END(tVACT_END),
    .active_mode(active_mode), .busy(busy), .frame_cnt(frame_cnt),
    .err_timeout(err_timeout), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input logic [1:0] m, input logic [3:0] f, input logic [15:0] d);
    bus.cfg_wr = 1'b1; bus.cfg_mode = m; bus.cfg_field = f; bus.cfg_data = d;
    tick();
    bus.cfg_wr = 1'b0;
    $display("cfg write mode=%0d field=%0d data=%0d", m, f, d);
  endtask

  task automatic writeMode(input logic [1:0] m, input int he, input int hss, input int hse,
                           input int has, input int hae, input int vss, input int vse,
                           input int vas, input int vae);
    cfgWrite(m, 4'd0, 16'(he));  cfgWrite(m, 4'd1, 16'(hss)); cfgWrite(m, 4'd2, 16'(hse));
    cfgWrite(m, 4'd3, 16'(has)); cfgWrite(m, 4'd4, 16'(hae)); cfgWrite(m, 4'd5, 16'(vss));
    cfgWrite(m, 4'd6, 16'(vse)); cfgWrite(m, 4'd7, 16'(vas)); cfgWrite(m, 4'd8, 16'(vae));
  endtask

  task automatic sendReq(input logic [1:0] m, input logic stop);
    bus.req_valid = 1'b1; bus.req_mode = m; bus.req_stop = stop;
    tick();
    bus.req_valid = 1'b0; bus.req_stop = 1'b0;
    $display("request mode=%0d stop=%0d at %0t", m, stop, $time);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vs = 1'b0;
    bus.cfg_wr = 1'b0; bus.cfg_mode = '0; bus.cfg_field = '0; bus.cfg_data = '0;
    bus.req_valid = 1'b0; bus.req_mode = '0; bus.req_stop = 1'b0;
    tick(); tick();
    total++; if (gen_rst_n !== 1'b0) $display("FAIL rst_gen: got %0d want 0", gen_rst_n); else passed++;
    total++; if (tH_END !== 12'd0) $display("FAIL rst_th: got %0d want 0", tH_END); else passed++;
    total++; if (tVACT_END !== 12'd0) $display("FAIL rst_tv: got %0d want 0", tVACT_END); else passed++;
    total++; if (active_mode !== 2'd0) $display("FAIL rst_mode: got %0d want 0", active_mode); else passed++;
    total++; if (frame_cnt !== 16'd0) $display("FAIL rst_frame: got %0d want 0", frame_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %0d want 0", busy); else passed++;
    total++; if ({err_timeout, err_cfg} !== 2'b00) $display("FAIL rst_err: got %b want 00", {err_timeout, err_cfg}); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (bus.req_ready !== 1'b1) $display("FAIL rst_ready: got %0d want 1", bus.req_ready); else passed++;
  endtask

  task automatic test_idle_switch();
    writeMode(2'd1, 99, 10, 20, 30, 90, 2, 4, 5, 50);
    writeMode(2'd2, 199, 12, 24, 40, 180, 3, 6, 10, 100);
    total++; if (tH_END !== 12'd0) $display("FAIL idle_nowrite: got %0d want 0", tH_END); else passed++;
    sendReq(2'd1, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL idle_busy: got %0d want 1", busy); else passed++;
    tick(); tick(); tick();
    total++; if (gen_rst_n !== 1'b0) $display("FAIL idle_gen3: got %0d want 0", gen_rst_n); else passed++;
    total++; if (tH_END !== 12'd0) $display("FAIL idle_th3: got %0d want 0", tH_END); else passed++;
    tick();
    total++; if (gen_rst_n !== 1'b1) $display("FAIL idle_gen4: got %0d want 1", gen_rst_n); else passed++;
    total++; if ({tH_END, tHS_START, tHS_END, tHACT_START, tHACT_END} !== {12'd99, 12'd10, 12'd20, 12'd30, 12'd90})
      $display("FAIL idle_h: got %0d %0d %0d %0d %0d want 99 10 20 30 90", tH_END, tHS_START, tHS_END, tHACT_START, tHACT_END);
    else passed++;
    total++; if ({tVS_START, tVS_END, tVACT_START, tVACT_END} !== {12'd2, 12'd4, 12'd5, 12'd50})
      $display("FAIL idle_v: got %0d %0d %0d %0d want 2 4 5 50", tVS_START, tVS_END, tVACT_START, tVACT_END);
    else passed++;
    total++; if (active_mode !== 2'd1) $display("FAIL idle_mode: got %0d want 1", active_mode); else passed++;
    total++; if (frame_cnt !== 16'd0) $display("FAIL idle_frame: got %0d want 0", frame_cnt); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL idle_busy_done: got %0d want 0", busy); else passed++;
  endtask

  task automatic test_frame_cnt();
    vs = 1'b1; tick(); vs = 1'b0; tick();
    total++; if (frame_cnt !== 16'd1) $display("FAIL frame_1: got %0d want 1", frame_cnt); else passed++;
    for (int i = 0; i < 2; i++) begin
      vs = 1'b1; tick(); tick(); vs = 1'b0; tick();
    end
    total++; if (frame_cnt !== 16'd3) $display("FAIL frame_3: got %0d want 3", frame_cnt); else passed++;
  endtask

  task automatic test_vs_switch();
    sendReq(2'd2, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL vsw_busy: got %0d want 1", busy); else passed++;
    total++; if (bus.req_ready !== 1'b0) $display("FAIL vsw_ready: got %0d want 0", bus.req_ready); else passed++;
    tick(); tick(); tick();
    total++; if (gen_rst_n !== 1'b1) $display("FAIL vsw_wait_gen: got %0d want 1", gen_rst_n); else passed++;
    total++; if (tH_END !== 12'd99) $display("FAIL vsw_wait_th: got %0d want 99", tH_END); else passed++;
    vs = 1'b1; tick();
    total++; if (gen_rst_n !== 1'b0) $display("FAIL vsw_fall: got %0d want 0", gen_rst_n); else passed++;
    total++; if (active_mode !== 2'd1) $display("FAIL vsw_hold_mode: got %0d want 1", active_mode); else passed++;
    tick(); tick(); tick();
    total++; if (gen_rst_n !== 1'b0) $display("FAIL vsw_gen3: got %0d want 0", gen_rst_n); else passed++;
    tick();
    total++; if (gen_rst_n !== 1'b1) $display("FAIL vsw_gen4: got %0d want 1", gen_rst_n); else passed++;
    total++; if ({tH_END, tHACT_END, tVACT_END} !== {12'd199, 12'd180, 12'd100})
      $display("FAIL vsw_load: got %0d %0d %0d want 199 180 100", tH_END, tHACT_END, tVACT_END);
    else passed++;
    total++; if (active_mode !== 2'd2) $display("FAIL vsw_mode: got %0d want 2", active_mode); else passed++;
    total++; if (frame_cnt !== 16'd0) $display("FAIL vsw_frame: got %0d want 0", frame_cnt); else passed++;
    vs = 1'b0; tick();
  endtask

  task automatic test_timeout();
    sendReq(2'd1, 1'b0);
    for (int i = 0; i < 15; i++) tick();
    total++; if (gen_rst_n !== 1'b1) $display("FAIL to_gen15: got %0d want 1", gen_rst_n); else passed++;
    total++; if (err_timeout !== 1'b0) $display("FAIL to_err15: got %0d want 0", err_timeout); else passed++;
    tick();
    total++; if (gen_rst_n !== 1'b0) $display("FAIL to_gen16: got %0d want 0", gen_rst_n); else passed++;
    total++; if (err_timeout !== 1'b1) $display("FAIL to_err16: got %0d want 1", err_timeout); else passed++;
    tick(); tick(); tick(); tick();
    total++; if ({gen_rst_n, active_mode} !== {1'b1, 2'd1}) $display("FAIL to_load: got gen=%0d mode=%0d want gen=1 mode=1", gen_rst_n, active_mode); else passed++;
    total++; if (err_timeout !== 1'b1) $display("FAIL to_sticky: got %0d want 1", err_timeout); else passed++;
  endtask

  task automatic test_rewrite_same_mode();
    cfgWrite(2'd1, 4'd0, 16'd120);
    total++; if (tH_END !== 12'd99) $display("FAIL rw_nochange: got %0d want 99", tH_END); else passed++;
    sendReq(2'd1, 1'b0);
    total++; if (err_timeout !== 1'b0) $display("FAIL rw_errclr: got %0d want 0", err_timeout); else passed++;
    vs = 1'b1; tick(); vs = 1'b0;
    tick(); tick(); tick();
    // LOAD cycle: simultaneous write to the entry being loaded
    bus.cfg_wr = 1'b1; bus.cfg_mode = 2'd1; bus.cfg_field = 4'd0; bus.cfg_data = 16'd130;
    tick();
    bus.cfg_wr = 1'b0;
    total++; if (tH_END !== 12'd120) $display("FAIL rw_load: got %0d want 120", tH_END); else passed++;
    total++; if (tHS_START !== 12'd10) $display("FAIL rw_other: got %0d want 10", tHS_START); else passed++;
    total++; if (gen_rst_n !== 1'b1) $display("FAIL rw_gen: got %0d want 1", gen_rst_n); else passed++;
  endtask

  task automatic test_stop();
    sendReq(2'd2, 1'b1);
    total++; if (busy !== 1'b1) $display("FAIL stop_busy: got %0d want 1", busy); else passed++;
    vs = 1'b1; tick(); vs = 1'b0;
    total++; if (gen_rst_n !== 1'b0) $display("FAIL stop_fall: got %0d want 0", gen_rst_n); else passed++;
    tick(); tick(); tick();
    total++; if ({busy, bus.req_ready, gen_rst_n} !== 3'b010) $display("FAIL stop_idle: got %b want 010", {busy, bus.req_ready, gen_rst_n}); else passed++;
    total++; if ({active_mode, tH_END} !== {2'd1, 12'd120}) $display("FAIL stop_keep: got mode=%0d th=%0d want mode=1 th=120", active_mode, tH_END); else passed++;
    sendReq(2'd0, 1'b1);
    tick();
    total++; if ({busy, gen_rst_n} !== 2'b00) $display("FAIL stop_noop: got %b want 00", {busy, gen_rst_n}); else passed++;
  endtask

  task automatic test_cfg_check();
    writeMode(2'd3, 99, 20, 20, 30, 90, 2, 4, 5, 50);
    sendReq(2'd3, 1'b0);
    tick(); tick(); tick(); tick();
`ifdef VTPG_CTRL_CHECK_EN
    total++; if (err_cfg !== 1'b1) $display("FAIL chk_err: got %0d want 1", err_cfg); else passed++;
    total++; if ({gen_rst_n, busy} !== 2'b00) $display("FAIL chk_gen: got %b want 00", {gen_rst_n, busy}); else passed++;
    total++; if ({active_mode, tH_END} !== {2'd1, 12'd120}) $display("FAIL chk_keep: got mode=%0d th=%0d want mode=1 th=120", active_mode, tH_END); else passed++;
`else
    total++; if (err_cfg !== 1'b0) $display("FAIL chk_err: got %0d want 0", err_cfg); else passed++;
    total++; if (gen_rst_n !== 1'b1) $display("FAIL chk_gen: got %0d want 1", gen_rst_n); else passed++;
    total++; if ({active_mode, tHS_START} !== {2'd3, 12'd20}) $display("FAIL chk_load: got mode=%0d hs=%0d want mode=3 hs=20", active_mode, tHS_START); else passed++;
`endif
  endtask

  task automatic test_async_reset();
    sendReq(2'd2, 1'b0);
    vs = 1'b1; tick();
    total++; if ({busy, gen_rst_n} !== 2'b10) $display("FAIL ar_hold: got %b want 10", {busy, gen_rst_n}); else passed++;
    #1 rst_n = 1'b0;
    #1;
    total++; if ({gen_rst_n, busy, err_timeout, err_cfg} !== 4'b0000) $display("FAIL ar_flags: got %b want 0000", {gen_rst_n, busy, err_timeout, err_cfg}); else passed++;
    total++; if ({tH_END, tVACT_END} !== 24'd0) $display("FAIL ar_timing: got %0d %0d want 0 0", tH_END, tVACT_END); else passed++;
    total++; if ({active_mode, frame_cnt} !== 18'd0) $display("FAIL ar_mode: got mode=%0d frame=%0d want 0 0", active_mode, frame_cnt); else passed++;
    vs = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    writeMode(2'd1, 99, 10, 20, 30, 90, 2, 4, 5, 50);
    sendReq(2'd1, 1'b0);
    tick(); tick(); tick(); tick();
    total++; if ({gen_rst_n, active_mode, busy} !== {1'b1, 2'd1, 1'b0}) $display("FAIL ar_after: got gen=%0d mode=%0d busy=%0d want 1 1 0", gen_rst_n, active_mode, busy); else passed++;
    total++; if (tH_END !== 12'd99) $display("FAIL ar_after_th: got %0d want 99", tH_END); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle_switch();
    test_frame_cnt();
    test_vs_switch();
    test_timeout();
    test_rewrite_same_mode();
    test_stop();
    test_cfg_check();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
